// File: rtl/fc8_sat_dma_if.sv
// fc8_sat_dma bus bundle: SFR start/config, CPU-memory read handshake, SAT write port, status.
// master = DMA engine side, slave = SFR/memory/SAT side.
interface fc8_sat_dma_if #(
  parameter int unsigned SAT_ADDR_W = 10,
  parameter int unsigned SRC_ADDR_W = 16
);
  logic                  start_in;
  logic [7:0]            src_page_in;
  logic [7:0]            len_in;
  logic [7:0]            sat_off_in;
  logic                  vblank_in;
  logic                  mem_rd_req_out;
  logic [SRC_ADDR_W-1:0] mem_addr_out;
  logic                  mem_rd_valid_in;
  logic [7:0]            mem_rd_data_in;
  logic                  sat_wr_en_out;
  logic [SAT_ADDR_W-1:0] sat_wr_addr_out;
  logic [7:0]            sat_wr_data_out;
  logic                  cpu_halt_out;
  logic                  busy_out;
  logic                  done_out;
  logic                  start_ignored_out;

  modport master (
    input  start_in, src_page_in, len_in, sat_off_in, vblank_in,
           mem_rd_valid_in, mem_rd_data_in,
    output mem_rd_req_out, mem_addr_out, sat_wr_en_out, sat_wr_addr_out,
           sat_wr_data_out, cpu_halt_out, busy_out, done_out, start_ignored_out
  );

  modport slave (
    output start_in, src_page_in, len_in, sat_off_in, vblank_in,
           mem_rd_valid_in, mem_rd_data_in,
    input  mem_rd_req_out, mem_addr_out, sat_wr_en_out, sat_wr_addr_out,
           sat_wr_data_out, cpu_halt_out, busy_out, done_out, start_ignored_out
  );
endinterface

// File: rtl/fc8_sat_dma.sv
// SAT DMA writer: copies up to 256 bytes from a CPU memory page into the SAT while halting the CPU.
// Optional macro FC8_SAT_DMA_VBLANK_GATE_EN restricts memory reads/SAT writes to vertical blank.
module fc8_sat_dma #(
  parameter int unsigned SAT_BYTES  = 256,
  parameter int unsigned SAT_ADDR_W = 10,
  parameter int unsigned SRC_ADDR_W = 16,
  parameter int unsigned SAT_BASE   = 0
) (
  input  logic          clk,
  input  logic          rst,
  fc8_sat_dma_if.master bus
);

`ifdef FC8_SAT_DMA_VBLANK_GATE_EN
  typedef enum logic [2:0] {IDLE, REQ, WRITE, DONE, WAIT_VB} state_e;
`else
  typedef enum logic [1:0] {IDLE, REQ, WRITE, DONE} state_e;
`endif

  localparam logic [SAT_ADDR_W-1:0] SatBase = SAT_ADDR_W'(SAT_BASE);

  state_e                state_q;
  logic [7:0]            src_page_q;
  logic [7:0]            src_idx_q;
  logic [7:0]            sat_idx_q;
  logic [8:0]            remaining_q;
  logic                  req_q;
  logic [SRC_ADDR_W-1:0] addr_q;
  logic                  wr_en_q;
  logic [SAT_ADDR_W-1:0] wr_addr_q;
  logic [7:0]            wr_data_q;
  logic                  busy_q;
  logic                  done_q;
  logic                  ign_q;

  logic [7:0]            src_idx_d;
  logic [7:0]            sat_idx_d;
  logic [8:0]            remaining_d;

  function automatic logic [SRC_ADDR_W-1:0] src_addr(input logic [7:0] page,
                                                     input logic [7:0] idx);
    return SRC_ADDR_W'({page, 8'h00}) + SRC_ADDR_W'(idx);
  endfunction

  always_comb begin
    src_idx_d   = src_idx_q + 8'd1;
    sat_idx_d   = sat_idx_q + 8'd1;
    remaining_d = remaining_q - 9'd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      src_page_q  <= '0;
      src_idx_q   <= '0;
      sat_idx_q   <= '0;
      remaining_q <= '0;
      req_q       <= 1'b0;
      addr_q      <= '0;
      wr_en_q     <= 1'b0;
      wr_addr_q   <= '0;
      wr_data_q   <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      ign_q       <= 1'b0;
    end else begin
      wr_en_q <= 1'b0;
      done_q  <= 1'b0;
      ign_q   <= bus.start_in && (state_q != IDLE);
      case (state_q)
        IDLE: begin
          if (bus.start_in) begin
            src_page_q  <= bus.src_page_in;
            src_idx_q   <= '0;
            sat_idx_q   <= bus.sat_off_in;
            remaining_q <= (bus.len_in == 8'd0) ? 9'(SAT_BYTES) : {1'b0, bus.len_in};
            busy_q      <= 1'b1;
`ifdef FC8_SAT_DMA_VBLANK_GATE_EN
            state_q     <= WAIT_VB;
`else
            state_q     <= REQ;
            req_q       <= 1'b1;
            addr_q      <= src_addr(bus.src_page_in, 8'h00);
`endif
          end
        end
`ifdef FC8_SAT_DMA_VBLANK_GATE_EN
        WAIT_VB: begin
          if (bus.vblank_in) begin
            state_q <= REQ;
            req_q   <= 1'b1;
            addr_q  <= src_addr(src_page_q, src_idx_q);
          end
        end
`endif
        REQ: begin
          if (bus.mem_rd_valid_in) begin
            req_q     <= 1'b0;
            wr_en_q   <= 1'b1;
            wr_data_q <= bus.mem_rd_data_in;
            wr_addr_q <= SatBase + SAT_ADDR_W'(sat_idx_q);
            state_q   <= WRITE;
          end
`ifdef FC8_SAT_DMA_VBLANK_GATE_EN
          else if (!bus.vblank_in) begin
            req_q   <= 1'b0;
            state_q <= WAIT_VB;
          end
`endif
        end
        WRITE: begin
          src_idx_q   <= src_idx_d;
          sat_idx_q   <= sat_idx_d;
          remaining_q <= remaining_d;
          if (remaining_q == 9'd1) begin
            done_q  <= 1'b1;
            state_q <= DONE;
          end
`ifdef FC8_SAT_DMA_VBLANK_GATE_EN
          // Leaving vblank between bytes parks before the next read is issued.
          else if (!bus.vblank_in) begin
            state_q <= WAIT_VB;
          end
`endif
          else begin
            state_q <= REQ;
            req_q   <= 1'b1;
            addr_q  <= src_addr(src_page_q, src_idx_d);
          end
        end
        DONE: begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

`ifndef FC8_SAT_DMA_VBLANK_GATE_EN
  logic unused_vblank;
  assign unused_vblank = bus.vblank_in;
`endif

  assign bus.mem_rd_req_out    = req_q;
  assign bus.mem_addr_out      = addr_q;
  assign bus.sat_wr_en_out     = wr_en_q;
  assign bus.sat_wr_addr_out   = wr_addr_q;
  assign bus.sat_wr_data_out   = wr_data_q;
  assign bus.cpu_halt_out      = busy_q;
  assign bus.busy_out          = busy_q;
  assign bus.done_out          = done_q;
  assign bus.start_ignored_out = ign_q;

endmodule

// File: doc/fc8_sat_dma.md
Name: fc8_sat_dma

Overview:
- DMA writer that fills the Sprite Attribute Table (SAT) in the SFR block from CPU-visible memory.
- It is the write side of the SAT; the sprite engine reads the SAT through its read port.
- Started by a CPU write to the DMA SFR. It holds the CPU via cpu_halt_out, copies up to 256 bytes over a request/valid memory read handshake, then writes each byte to the SAT write port and pulses done.

Parameters:
- SAT_BYTES, 256, SAT size in bytes (64 entries x 4 bytes).
- SAT_ADDR_W, 10, SAT address width; matches the SFR SAT port.
- SRC_ADDR_W, 16, CPU memory address width.
- SAT_BASE, 0, SAT address of byte 0.

Ports:
- clk  in  1  system clock; only clock in the block.
- rst  in  1  asynchronous, active-high reset.
- start_in  in  1  one-cycle pulse from the SFR write decode.
- src_page_in  in  8  source high byte; source address = {src_page_in, 8'h00} + byte index.
- len_in  in  8  byte count; 0 means 256.
- sat_off_in  in  8  first SAT byte offset.
- vblank_in  in  1  vertical blank flag from fc8_graphics (see Optional Feature).
- mem_rd_req_out  out  1  memory read request.
- mem_addr_out  out  SRC_ADDR_W  read address.
- mem_rd_valid_in  in  1  read data valid.
- mem_rd_data_in  in  8  read data.
- sat_wr_en_out  out  1  SAT write strobe.
- sat_wr_addr_out  out  SAT_ADDR_W  SAT write address.
- sat_wr_data_out  out  8  SAT write data.
- cpu_halt_out  out  1  stalls the CPU while the transfer runs.
- busy_out  out  1  transfer in progress.
- done_out  out  1  one-cycle completion pulse.
- start_ignored_out  out  1  one-cycle pulse when start_in arrives while busy.

Interface decision: one clock; reset is asynchronous and active-high.

Behaviour:
- Reset: every output is 0, the FSM is in IDLE, and all counters are 0. Asserting rst mid-transfer aborts immediately. SAT bytes already written stay written; no further write is issued.
- States: IDLE, REQ, WRITE, DONE.
- IDLE:
  - On start_in, latch src_page, remaining = (len_in==0 ? 256 : len_in), sat_idx = sat_off_in, and src_idx = 0.
  - Next state is REQ, or WAIT_VB when the optional feature is enabled.
  - busy_out and cpu_halt_out rise the cycle after start_in.
- REQ:
  - mem_rd_req_out = 1 and mem_addr_out = {src_page, 8'h00} + src_idx; both stay stable until mem_rd_valid_in.
  - On valid in this state, latch the data and go to WRITE.
  - mem_rd_valid_in outside REQ is ignored.
- WRITE:
  - sat_wr_en_out = 1 for exactly one cycle.
  - sat_wr_addr_out = SAT_BASE + sat_idx, where sat_idx is 8 bits and wraps 255 -> 0 (offset plus length wraps inside the SAT).
  - src_idx and sat_idx increment and remaining decrements. If remaining was 1, go to DONE; otherwise go to REQ.
  - src_idx is 8 bits, so the source never crosses its page.
- DONE:
  - done_out = 1 for one cycle, then IDLE.
  - busy_out and cpu_halt_out are high in REQ, WRITE and DONE, and drop in IDLE.
- Throughput: 2 cycles per byte with zero-wait memory (valid in the same cycle as the request), so 256 bytes take 512 cycles plus 1 DONE cycle.
- start_in in any state other than IDLE, including DONE: ignored, and start_ignored_out pulses the next cycle.
- No SAT write happens outside WRITE. sat_wr_addr_out and sat_wr_data_out hold their last values when not strobing.

Optional Feature:
- Macro: FC8_SAT_DMA_VBLANK_GATE_EN.
- With the macro defined:
  - An extra WAIT_VB state is added; start goes IDLE -> WAIT_VB, which moves to REQ only when vblank_in == 1.
  - In REQ, if vblank_in == 0 and no request is outstanding (valid not yet seen), the FSM returns to WAIT_VB with mem_rd_req_out dropped.
  - WRITE always completes its cycle.
  - cpu_halt_out stays high in WAIT_VB.
  - This guarantees the sprite engine never sees a partial SAT during active display.
- Without the macro: vblank_in is unused and start goes straight to REQ.

Test Plan:
- Page 8'h02, len 0, offset 0, zero-wait memory returning addr[7:0] -> 256 SAT writes, addr 0..255 with data 0..255, done_out at cycle 513 after start, cpu_halt_out then low.
- len 4, offset 8'hFE -> SAT writes at 254, 255, 0, 1 with source 0x0200..0x0203; exactly 4 strobes.
- Memory valid delayed 3 cycles per read, len 2 -> mem_addr_out held stable throughout; 2 strobes; no early write.
- start_in pulsed during REQ and again during DONE -> start_ignored_out pulses twice; transfer parameters unchanged.
- rst asserted after 10 writes of a 256-byte transfer -> all outputs 0 at once; no further strobes; a new start succeeds.
- With FC8_SAT_DMA_VBLANK_GATE_EN, vblank_in low at start, high 20 cycles later, low again mid-transfer -> no request before vblank, pause while low, full completion after vblank returns.
